// File: rtl/fir_frame_sequencer_if.sv
// Signal bundle between the frame sequencer, its host stream, the FIR datapath
// and the result consumer. The sequencer uses the slave modport.
interface fir_frame_sequencer_if #(
  parameter int DATA_W     = 8,
  parameter int RES_W      = 16,
  parameter int TAPS       = 16,
  parameter int FIFO_DEPTH = 8
);
  logic [DATA_W-1:0]             s_data;
  logic                          s_valid;
  logic                          s_ready;
  logic [DATA_W-1:0]             smp_out;
  logic                          smp_strobe;
  logic [$clog2(TAPS)-1:0]       tap_idx;
  logic                          acc_clr;
  logic                          acc_en;
  logic [RES_W-1:0]              y_in;
  logic [RES_W-1:0]              m_data;
  logic                          m_valid;
  logic                          m_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport master (
    output s_data, s_valid, y_in, m_ready,
    input  s_ready, smp_out, smp_strobe, tap_idx, acc_clr, acc_en,
           m_data, m_valid, fifo_level
  );

  modport slave (
    input  s_data, s_valid, y_in, m_ready,
    output s_ready, smp_out, smp_strobe, tap_idx, acc_clr, acc_en,
           m_data, m_valid, fifo_level
  );
endinterface

// File: rtl/fir_frame_sequencer.sv
// Control end of a serial FIR: buffers host samples, runs one LOAD/MAC/DRAIN
// frame per sample and hands the captured accumulator result to the consumer.
module fir_frame_sequencer #(
  parameter int DATA_W     = 8,
  parameter int RES_W      = 16,
  parameter int TAPS       = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ACC_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_frame_sequencer_if.slave   bus
);
  localparam int TW = $clog2(TAPS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(ACC_LAT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, EMIT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [LW-1:0]       lvl_q;
  logic [TW-1:0]       tap_q, tap_d;
  logic [CW-1:0]       lat_q, lat_d;
  logic [DATA_W-1:0]   smp_q, smp_d;
  logic [RES_W-1:0]    mdata_q, mdata_d;
  logic                mvalid_q, mvalid_d;
  logic                s_ready, push, pop;

  assign s_ready = reset && (lvl_q < LW'(FIFO_DEPTH));
  assign push    = bus.s_valid && s_ready;
  // Only LOAD pops, and LOAD is entered only with a non-empty FIFO.
  assign pop     = (state_q == LOAD);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      lat_q    <= '0;
      smp_q    <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      lat_q    <= lat_d;
      smp_q    <= smp_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
    end
  end

  // The head is latched on entry to LOAD so smp_out is already valid while
  // smp_strobe is high; the read pointer itself advances at the end of LOAD.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    lat_d    = lat_q;
    smp_d    = smp_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    case (state_q)
      IDLE: begin
        if (lvl_q != '0) begin
          state_d = LOAD;
          smp_d   = mem_q[rd_q];
        end
      end
      LOAD: begin
        state_d = MAC;
        tap_d   = '0;
      end
      MAC: begin
        tap_d = tap_q + 1'b1;
        if (tap_q == TW'(TAPS - 1)) begin
          state_d = DRAIN;
          lat_d   = '0;
        end
      end
      DRAIN: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == CW'(ACC_LAT - 1)) begin
          state_d  = EMIT;
          mdata_d  = bus.y_in;
          mvalid_d = 1'b1;
        end
      end
      EMIT: begin
        if (bus.m_ready) begin
          mvalid_d = 1'b0;
          if (lvl_q != '0) begin
            state_d = LOAD;
            smp_d   = mem_q[rd_q];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_ready    = s_ready;
  assign bus.smp_out    = smp_q;
  assign bus.smp_strobe = (state_q == LOAD);
  assign bus.tap_idx    = tap_q;
  assign bus.acc_clr    = !reset || (state_q == LOAD);
  assign bus.acc_en     = (state_q == MAC);
  assign bus.m_data     = mdata_q;
  assign bus.m_valid    = mvalid_q;
  assign bus.fifo_level = lvl_q;
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Bench: host stream driver, behavioural FIR (delay line + product/accumulator
// pipeline) feeding y_in, and a scoreboard of direct-form sums per sample.
module tb_fir_frame_sequencer;
  localparam int DW = 8, RW = 16, TAPS = 16, FD = 8, AL = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fir_frame_sequencer_if #(.DATA_W(DW), .RES_W(RW), .TAPS(TAPS), .FIFO_DEPTH(FD)) bus ();

  fir_frame_sequencer #(.DATA_W(DW), .RES_W(RW), .TAPS(TAPS), .FIFO_DEPTH(FD), .ACC_LAT(AL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic [7:0]  coef [TAPS];
  logic [7:0]  hist [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  strb_q [$];
  logic [15:0] res_q [$];
  int res_cyc [$], load_cyc [$], rise_cyc [$], push_cyc [$];
  int acc_cnt = 0, mv_cnt = 0, tap_err = 0, stall_err = 0, stab_err = 0, lvl_err = 0, rdy_err = 0;
  bit force_y = 1'b0;
  logic [15:0] force_val = '0;

  // Filter environment: delay line, product register, accumulator (2-cycle latency).
  logic [7:0]  dl [TAPS];
  logic [15:0] prod = '0, acc = '0;
  logic        aen_d = 1'b0;
  logic        n_rst, n_strb, n_aen, n_clr;
  logic [3:0]  n_tap;
  logic [7:0]  n_smp;

  assign bus.y_in = force_y ? force_val : acc;

  initial begin
    for (int k = 0; k < TAPS; k++) dl[k] = '0;
    forever begin
      @(negedge clk);
      n_rst = reset; n_strb = bus.smp_strobe; n_aen = bus.acc_en;
      n_clr = bus.acc_clr; n_tap = bus.tap_idx; n_smp = bus.smp_out;
      @(posedge clk);
      cyc = cyc + 1;
      if (!n_rst) begin
        for (int k = 0; k < TAPS; k++) dl[k] = '0;
        prod = '0; acc = '0; aen_d = 1'b0;
      end else begin
        if (n_clr) acc = '0;
        else if (aen_d) acc = acc + prod;
        aen_d = n_aen;
        if (n_aen) prod = 16'(32'(coef[n_tap]) * 32'(dl[n_tap]));
        if (n_strb) begin
          for (int k = TAPS - 1; k > 0; k--) dl[k] = dl[k-1];
          dl[0] = n_smp;
        end
      end
    end
  end

  // Host: offers tx_q head, holds it until accepted.
  initial begin
    bit hs;
    bus.s_valid = 1'b0; bus.s_data = '0;
    forever begin
      @(negedge clk);
      hs = bus.s_valid && bus.s_ready && reset;
      if (hs) push_cyc.push_back(cyc);
      @(posedge clk);
      if (hs && tx_q.size() > 0) hist.push_back(tx_q.pop_front());
      #1;
      if (tx_q.size() > 0) begin bus.s_valid = 1'b1; bus.s_data = tx_q[0]; end
      else bus.s_valid = 1'b0;
    end
  end

  // Observation log.
  initial begin
    logic [3:0] exp_tap; logic prev_mv, prev_hs; logic [15:0] prev_md;
    exp_tap = '0; prev_mv = 1'b0; prev_hs = 1'b0; prev_md = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.smp_strobe) begin strb_q.push_back(bus.smp_out); load_cyc.push_back(cyc); exp_tap = '0; end
        if (bus.acc_en) begin acc_cnt++; if (bus.tap_idx !== exp_tap) tap_err++; exp_tap = exp_tap + 1'b1; end
        if (bus.m_valid && (bus.acc_en || bus.smp_strobe)) stall_err++;
        if (prev_mv && !prev_hs && (!bus.m_valid || bus.m_data !== prev_md)) stab_err++;
        if (bus.m_valid && !prev_mv) rise_cyc.push_back(cyc);
        if (bus.m_valid) mv_cnt++;
        if (bus.m_valid && bus.m_ready) begin res_q.push_back(bus.m_data); res_cyc.push_back(cyc); end
        if (bus.fifo_level > 4'(FD)) lvl_err++;
        if (bus.s_ready !== (bus.fifo_level < 4'(FD))) rdy_err++;
        prev_mv = bus.m_valid; prev_md = bus.m_data; prev_hs = bus.m_valid && bus.m_ready;
      end else begin
        prev_mv = 1'b0; prev_hs = 1'b0;
      end
    end
  end

  // y[n] = sum_k coef[k] * x[n-k], x before the first sample since reset is zero.
  function automatic logic [15:0] model(input int n);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < TAPS; k++)
      if (n - k >= 0) s = s + 32'(coef[k]) * 32'(hist[n-k]);
    return s[15:0];
  endfunction

  task automatic clear_logs();
    hist.delete(); tx_q.delete(); strb_q.delete(); res_q.delete();
    res_cyc.delete(); load_cyc.delete(); rise_cyc.delete(); push_cyc.delete();
    acc_cnt = 0; mv_cnt = 0; tap_err = 0; stall_err = 0; stab_err = 0; lvl_err = 0; rdy_err = 0;
  endtask

  task automatic wait_res(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (res_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    n_cmp++; if (bus.acc_clr !== 1'b1) begin n_bad++; $display("FAIL rst_acc_clr: got %b want 1", bus.acc_clr); end
    n_cmp++; if ({bus.smp_strobe, bus.acc_en, bus.m_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_ctrl: got %b want 000", {bus.smp_strobe, bus.acc_en, bus.m_valid}); end
    n_cmp++; if (bus.tap_idx !== 4'd0 || bus.smp_out !== 8'd0) begin n_bad++; $display("FAIL rst_tap_smp: got %h/%h want 0/0", bus.tap_idx, bus.smp_out); end
    n_cmp++; if (bus.m_data !== 16'd0 || bus.fifo_level !== 4'd0) begin n_bad++; $display("FAIL rst_data_lvl: got %h/%h want 0/0", bus.m_data, bus.fifo_level); end
    @(posedge clk); #2; reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.s_ready !== 1'b1 || bus.acc_clr !== 1'b0) begin n_bad++; $display("FAIL rst_release: got rdy=%b clr=%b want 1/0", bus.s_ready, bus.acc_clr); end
    clear_logs();
  endtask

  task automatic test_single();
    int r0, s0, a0, m0, p0; bit ok;
    force_y = 1'b1; force_val = 16'h0123; bus.m_ready = 1'b1;
    r0 = res_q.size(); s0 = strb_q.size(); a0 = acc_cnt; m0 = mv_cnt; p0 = push_cyc.size();
    tx_q.push_back(8'h05);
    wait_res(r0 + 1, 100, ok);
    repeat (5) @(posedge clk); #2;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got %0d results want %0d", res_q.size() - r0, 1); end
    if (ok) begin
      n_cmp++; if (strb_q.size() - s0 != 1 || strb_q[s0] !== 8'h05) begin n_bad++; $display("FAIL single_strobe: got %0d strobes smp=%h want 1 smp=05", strb_q.size() - s0, strb_q[s0]); end
      n_cmp++; if (acc_cnt - a0 != 16 || tap_err != 0) begin n_bad++; $display("FAIL single_mac: got acc_en=%0d tap_err=%0d want 16/0", acc_cnt - a0, tap_err); end
      n_cmp++; if (res_q[r0] !== 16'h0123) begin n_bad++; $display("FAIL single_result: got %h want 0123", res_q[r0]); end
      n_cmp++; if (rise_cyc[r0] - load_cyc[s0] != 19) begin n_bad++; $display("FAIL single_latency: got %0d want 19", rise_cyc[r0] - load_cyc[s0]); end
      n_cmp++; if (mv_cnt - m0 != 1) begin n_bad++; $display("FAIL single_mvalid_len: got %0d want 1", mv_cnt - m0); end
      n_cmp++; if (load_cyc[s0] - push_cyc[p0] != 2) begin n_bad++; $display("FAIL single_push_to_load: got %0d want 2", load_cyc[s0] - push_cyc[p0]); end
    end
    force_y = 1'b0;
  endtask

  task automatic test_burst_stall();
    int r0, s0, s1, a1; bit ok; logic [15:0] md; int seq_bad, val_bad;
    r0 = res_q.size(); s0 = strb_q.size(); bus.m_ready = 1'b1;
    for (int i = 1; i <= 10; i++) tx_q.push_back(8'(i));
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin @(posedge clk); #2; if (bus.fifo_level == 4'd8) begin ok = 1'b1; break; end end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_fill: got level %0d want 8", bus.fifo_level); end
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL burst_full_ready: got %b want 0", bus.s_ready); end
    n_cmp++; if (bus.s_valid !== 1'b1 || bus.s_data !== 8'd10) begin n_bad++; $display("FAIL burst_hold: got v=%b d=%0d want 1/10", bus.s_valid, bus.s_data); end
    for (int i = 0; i < 100; i++) begin @(posedge clk); #2; if (res_q.size() > r0) break; end
    bus.m_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin @(posedge clk); #2; if (bus.m_valid) begin ok = 1'b1; break; end end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_mvalid_timeout: got %b want 1", bus.m_valid); end
    s1 = strb_q.size(); a1 = acc_cnt; md = bus.m_data;
    repeat (50) @(posedge clk); #2;
    n_cmp++; if (strb_q.size() != s1 || acc_cnt != a1 || stall_err != 0) begin n_bad++; $display("FAIL stall_activity: got strb=%0d acc=%0d want 0/0", strb_q.size() - s1, acc_cnt - a1); end
    n_cmp++; if (bus.m_data !== md || bus.m_valid !== 1'b1 || stab_err != 0) begin n_bad++; $display("FAIL stall_hold: got %h v=%b want %h v=1", bus.m_data, bus.m_valid, md); end
    n_cmp++; if (bus.fifo_level !== 4'd8 || bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL stall_level: got %0d rdy=%b want 8/0", bus.fifo_level, bus.s_ready); end
    bus.m_ready = 1'b1;
    wait_res(r0 + 10, 400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_timeout: got %0d results want 10", res_q.size() - r0); end
    if (ok) begin
      seq_bad = 0; val_bad = 0;
      for (int i = 0; i < 10; i++) if (strb_q[s0+i] !== 8'(i + 1)) seq_bad++;
      for (int i = 0; i < 10; i++) if (res_q[r0+i] !== model(r0 + i)) val_bad++;
      n_cmp++; if (seq_bad != 0 || strb_q.size() - s0 != 10) begin n_bad++; $display("FAIL burst_order: got %0d bad of %0d strobes want 0 of 10", seq_bad, strb_q.size() - s0); end
      n_cmp++; if (val_bad != 0) begin n_bad++; $display("FAIL burst_values: got %0d wrong want 0 (first %h vs %h)", val_bad, res_q[r0], model(r0)); end
      n_cmp++; if (load_cyc[s0+2] != res_cyc[r0+1] + 1) begin n_bad++; $display("FAIL stall_load_after_hs: got %0d want %0d", load_cyc[s0+2], res_cyc[r0+1] + 1); end
    end
  endtask

  task automatic test_stream();
    int r0, a0, gap_bad, val_bad; bit ok;
    r0 = res_q.size(); a0 = acc_cnt; bus.m_ready = 1'b1;
    for (int i = 0; i < 32; i++) tx_q.push_back(8'($urandom));
    wait_res(r0 + 32, 32 * 20 + 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stream_timeout: got %0d results want 32", res_q.size() - r0); end
    if (ok) begin
      gap_bad = 0; val_bad = 0;
      for (int i = 0; i < 32; i++) begin
        if (res_q[r0+i] !== model(r0 + i)) val_bad++;
        if (i > 0 && res_cyc[r0+i] - res_cyc[r0+i-1] != 20) gap_bad++;
      end
      n_cmp++; if (val_bad != 0) begin n_bad++; $display("FAIL stream_values: got %0d wrong want 0", val_bad); end
      n_cmp++; if (gap_bad != 0) begin n_bad++; $display("FAIL stream_spacing: got %0d bad gaps want 0", gap_bad); end
      n_cmp++; if (acc_cnt - a0 != 32 * 16 || tap_err != 0) begin n_bad++; $display("FAIL stream_mac: got acc=%0d tap_err=%0d want 512/0", acc_cnt - a0, tap_err); end
    end
    n_cmp++; if (lvl_err != 0 || rdy_err != 0) begin n_bad++; $display("FAIL stream_level: got lvl_err=%0d rdy_err=%0d want 0/0", lvl_err, rdy_err); end
  endtask

  task automatic test_emit_push();
    int r0, s0; bit ok;
    r0 = res_q.size(); s0 = strb_q.size(); bus.m_ready = 1'b0;
    tx_q.push_back(8'($urandom));
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin @(posedge clk); #2; if (bus.m_valid) begin ok = 1'b1; break; end end
    n_cmp++; if (!ok || bus.fifo_level !== 4'd0) begin n_bad++; $display("FAIL emit_setup: got v=%b lvl=%0d want 1/0", bus.m_valid, bus.fifo_level); end
    tx_q.push_back(8'($urandom));
    @(posedge clk); #2; bus.m_ready = 1'b1;
    wait_res(r0 + 2, 80, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL emit_timeout: got %0d results want 2", res_q.size() - r0); end
    if (ok) begin
      n_cmp++; if (push_cyc[push_cyc.size()-1] != res_cyc[r0]) begin n_bad++; $display("FAIL emit_push_cycle: got %0d want %0d", push_cyc[push_cyc.size()-1], res_cyc[r0]); end
      n_cmp++; if (load_cyc[s0+1] - res_cyc[r0] != 2) begin n_bad++; $display("FAIL emit_idle_load: got %0d want 2", load_cyc[s0+1] - res_cyc[r0]); end
      n_cmp++; if (res_q[r0] !== model(r0) || res_q[r0+1] !== model(r0 + 1)) begin n_bad++; $display("FAIL emit_values: got %h %h want %h %h", res_q[r0], res_q[r0+1], model(r0), model(r0 + 1)); end
    end
  endtask

  task automatic test_reset_mid_mac();
    bit ok;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin @(posedge clk); #2; if (bus.acc_en && bus.tap_idx == 4'd7) begin ok = 1'b1; break; end end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL midmac_reach: got tap %0d want 7", bus.tap_idx); end
    reset = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if (bus.m_valid !== 1'b0 || bus.fifo_level !== 4'd0) begin n_bad++; $display("FAIL midmac_state: got v=%b lvl=%0d want 0/0", bus.m_valid, bus.fifo_level); end
    n_cmp++; if (bus.tap_idx !== 4'd0 || bus.acc_clr !== 1'b1 || bus.acc_en !== 1'b0) begin n_bad++; $display("FAIL midmac_ctrl: got tap=%0d clr=%b en=%b want 0/1/0", bus.tap_idx, bus.acc_clr, bus.acc_en); end
    reset = 1'b1;
    clear_logs();
    repeat (60) @(posedge clk); #2;
    n_cmp++; if (rise_cyc.size() != 0 || strb_q.size() != 0) begin n_bad++; $display("FAIL midmac_quiet: got rises=%0d strobes=%0d want 0/0", rise_cyc.size(), strb_q.size()); end
    tx_q.push_back(8'($urandom));
    wait_res(1, 60, ok);
    n_cmp++; if (!ok || res_q[0] !== model(0)) begin n_bad++; $display("FAIL midmac_recover: got %h want %h", res_q[0], model(0)); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_ready = 1'b0;
    for (int k = 0; k < TAPS; k++) coef[k] = 8'($urandom);
    test_reset();
    test_single();
    test_burst_stall();
    test_stream();
    test_emit_push();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_frame_sequencer.md
Name: fir_frame_sequencer

Overview:
- Producer/control end of the 16-tap serial FIR datapath.
- Accepts input samples from a host over a valid/ready stream and buffers them in a small FIFO.
- Per sample, drives the filter's sample shift, tap index (mux select and coefficient address) and accumulator clear/enable as single-clock enables (no derived clocks).
- Captures the finished accumulator result and returns it on a valid/ready output stream.

Parameters:
- DATA_W, 8, input sample width.
- RES_W, 16, accumulator/result width.
- TAPS, 16, MAC cycles per frame; power of two.
- FIFO_DEPTH, 8, input FIFO entries; power of two, ≥2.
- ACC_LAT, 2, cycles from last acc_en to a valid y_in (product register + accumulator).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-low; clears all state when sampled low at a clk edge.
- s_data  in  DATA_W  host sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full.
- smp_out  out  DATA_W  sample presented to the filter delay line input.
- smp_strobe  out  1  one-cycle shift enable for the delay line.
- tap_idx  out  log2(TAPS)  tap select / coefficient address.
- acc_clr  out  1  accumulator synchronous clear.
- acc_en  out  1  accumulator/product register enable.
- y_in  in  RES_W  accumulator output.
- m_data  out  RES_W  filtered result.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts m_data.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0 at an edge):
  - FIFO empties.
  - FSM goes to IDLE.
  - Outputs: s_ready=0 during reset, 1 on the first cycle after; smp_out=0, smp_strobe=0, tap_idx=0, acc_clr=1 (held while reset is low), acc_en=0, m_data=0, m_valid=0, fifo_level=0.
  - Reset mid-frame abandons the frame; no partial result is emitted.
- FIFO:
  - Push when s_valid&&s_ready.
  - Pop only in the LOAD state.
  - s_ready = (level<FIFO_DEPTH).
  - Simultaneous push and pop at full is not possible, because s_ready=0 when full.
  - Simultaneous push and pop at any other level leaves the level unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if level>0, go to LOAD; else stay. All control outputs are 0.
  - LOAD (1 cycle):
    - Pop the FIFO head into smp_out (registered; holds until the next LOAD).
    - smp_strobe=1, acc_clr=1, tap_idx=0.
    - Go to MAC.
  - MAC (TAPS cycles):
    - acc_en=1; tap_idx increments 0..TAPS-1, one step per cycle.
    - After tap_idx=TAPS-1, go to DRAIN; tap_idx wraps to 0.
  - DRAIN (ACC_LAT cycles): acc_en=0. Then register m_data<=y_in, set m_valid=1, go to EMIT.
  - EMIT:
    - Hold m_data and m_valid stable until m_ready=1.
    - On the handshake cycle, clear m_valid. Then go to LOAD if level>0 (counting a push in the same cycle as not yet visible), else to IDLE.
- Latency:
  - Push into an empty FIFO while in IDLE: LOAD starts 2 cycles after the push edge.
  - LOAD to m_valid rising: 1+TAPS+ACC_LAT cycles (19 at defaults).
  - Back-to-back frames with m_ready tied high: one result every TAPS+ACC_LAT+2 = 20 cycles.
- Backpressure:
  - No new frame starts while a result is unaccepted.
  - Host input keeps filling the FIFO until full, then s_ready drops.
- Arithmetic: none internal. Results are passed through at RES_W; no rounding or saturation.

Test Plan:
- Reset mid-MAC (reset low at tap_idx=7) -> next cycle: m_valid=0, fifo_level=0, tap_idx=0, acc_clr=1; no m_valid appears afterwards without new input.
- Single sample 8'h05 into IDLE, m_ready=1, model accumulator fed y_in=16'h0123 -> smp_strobe once with smp_out=8'h05; tap_idx runs 0..15 with acc_en high for exactly 16 cycles; m_valid for one cycle with m_data=16'h0123, 19 cycles after LOAD.
- Burst of 10 samples, s_valid held high, no pops (m_ready=0 after the first result) -> s_ready falls when fifo_level=8; s_data is held until the FIFO drains; no sample is lost or duplicated, checked by sequence 1..10 appearing on smp_out in order.
- m_ready held low 50 cycles after m_valid -> m_data stable, no smp_strobe and no acc_en during the stall; LOAD occurs the cycle after the m_ready handshake.
- Continuous stream of 32 samples with m_ready=1 -> 32 results at a 20-cycle spacing; fifo_level never underflows; pointer wrap exercised.
- Push on the EMIT handshake cycle with an empty FIFO -> FSM goes to IDLE, then LOAD 2 cycles later.
